// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute/redirect/counter bundle between the core pipeline and branch_predict_ctrl.
// master is the pipeline side, slave is the predictor.
interface branch_predict_ctrl_if;
    logic        f_valid;
    logic        f_is_branch;
    logic [31:0] f_pc;
    logic [31:0] f_target;
    logic        f_pred_taken;
    logic        x_valid;
    logic [31:0] x_pc;
    logic [31:0] x_target;
    logic        x_taken;
    logic        x_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        cnt_clr;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    modport master (
        output f_valid, f_is_branch, f_pc, f_target,
        output x_valid, x_pc, x_target, x_taken, x_pred_taken, cnt_clr,
        input  f_pred_taken, redirect_valid, redirect_pc, flush,
        input  br_count, mispred_count
    );

    modport slave (
        input  f_valid, f_is_branch, f_pc, f_target,
        input  x_valid, x_pc, x_target, x_taken, x_pred_taken, cnt_clr,
        output f_pred_taken, redirect_valid, redirect_pc, flush,
        output br_count, mispred_count
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with mispredict-first redirect arbitration
// and branch/mispredict performance counters.
module branch_predict_ctrl #(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_ctrl_if.slave bus
);

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0] f_idx_s;
    logic [IDX_W-1:0] x_idx_s;
    logic             pred_s;
    logic             mispredict_s;
    logic             redirect_valid_s;
    logic [31:0]      redirect_pc_s;
    logic             flush_s;
    logic [31:0]      br_count_r;
    logic [31:0]      mispred_count_r;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    assign f_idx_s = bus.f_pc[IDX_W+1:2];
    assign x_idx_s = bus.x_pc[IDX_W+1:2];

    // Table training; reset parks every entry at weak not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (bus.x_valid) begin
            bht_r[x_idx_s] <= sat_next(bht_r[x_idx_s], bus.x_taken);
        end
    end

    // Performance counters; a same-cycle clear wins over the increment.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.cnt_clr) begin
            br_count_r      <= 32'd0;
            mispred_count_r <= 32'd0;
        end else begin
            if (bus.x_valid) begin
                br_count_r <= br_count_r + 32'd1;
            end
            if (mispredict_s) begin
                mispred_count_r <= mispred_count_r + 32'd1;
            end
        end
    end

    // Zero-latency prediction and redirect arbitration; the table read is pre-update.
    always_comb begin
        pred_s           = 1'b0;
        mispredict_s     = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = 32'd0;
        flush_s          = 1'b0;
        if (rst_n) begin
            pred_s       = bus.f_valid & bus.f_is_branch & bht_r[f_idx_s][1];
            mispredict_s = bus.x_valid & (bus.x_taken != bus.x_pred_taken);
            if (mispredict_s) begin
                redirect_valid_s = 1'b1;
                redirect_pc_s    = bus.x_taken ? bus.x_target : bus.x_pc + 32'd4;
                flush_s          = 1'b1;
            end else if (pred_s) begin
                redirect_valid_s = 1'b1;
                redirect_pc_s    = bus.f_target;
            end else begin
                redirect_valid_s = 1'b0;
                redirect_pc_s    = 32'd0;
            end
        end else begin
            pred_s = 1'b0;
        end
    end

    assign bus.f_pred_taken   = pred_s;
    assign bus.redirect_valid = redirect_valid_s;
    assign bus.redirect_pc    = redirect_pc_s;
    assign bus.flush          = flush_s;
    assign bus.br_count       = br_count_r;
    assign bus.mispred_count  = mispred_count_r;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a behavioural table/counter model queues the
// expected outputs for each driven cycle, and each test task pops and compares them inline.
module tb_branch_predict_ctrl;

    typedef struct packed {
        logic        pred;
        logic        rv;
        logic        fl;
        logic [31:0] rpc;
    } comb_t;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    logic [1:0]  m_bht [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;
    comb_t       comb_q [$];
    logic [63:0] cnt_q  [$];

    branch_predict_ctrl_if bus ();

    branch_predict_ctrl #(.BHT_ENTRIES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic comb_t obs();
        return {bus.f_pred_taken, bus.redirect_valid, bus.flush, bus.redirect_pc};
    endfunction

    // Drive one cycle of inputs (called just after a falling edge) and queue the expectation.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic [31:0] ftgt,
                        input logic xv, input logic [31:0] xpc, input logic [31:0] xtgt,
                        input logic xt, input logic xpt, input logic clr);
        comb_t e;
        bus.f_valid = fv; bus.f_is_branch = fv; bus.f_pc = fpc; bus.f_target = ftgt;
        bus.x_valid = xv; bus.x_pc = xpc; bus.x_target = xtgt;
        bus.x_taken = xt; bus.x_pred_taken = xpt; bus.cnt_clr = clr;
        e = '0;
        if (rst_n) begin
            e.pred = fv & m_bht[fpc[7:2]][1];
            if (xv && (xt != xpt)) begin
                e.rv = 1'b1; e.fl = 1'b1;
                e.rpc = xt ? xtgt : xpc + 32'd4;
            end else if (e.pred) begin
                e.rv = 1'b1; e.rpc = ftgt;
            end
        end
        comb_q.push_back(e);
        #1;
    endtask

    task automatic fetch_step(input logic [31:0] fpc, input logic [31:0] ftgt);
        step(1'b1, fpc, ftgt, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exec_step(input logic [31:0] xpc, input logic [31:0] xtgt,
                             input logic xt, input logic xpt);
        step(1'b0, 32'd0, 32'd0, 1'b1, xpc, xtgt, xt, xpt, 1'b0);
    endtask

    // Advance one clock, update the model with the inputs seen at the edge, queue counts.
    task automatic tick();
        int v;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
            m_br = 32'd0; m_mis = 32'd0;
        end else begin
            if (bus.x_valid) begin
                v = int'(m_bht[bus.x_pc[7:2]]) + (bus.x_taken ? 1 : -1);
                if (v > 3) v = 3;
                if (v < 0) v = 0;
                m_bht[bus.x_pc[7:2]] = 2'(v);
            end
            if (bus.cnt_clr) begin
                m_br = 32'd0; m_mis = 32'd0;
            end else begin
                if (bus.x_valid) m_br = m_br + 32'd1;
                if (bus.x_valid && (bus.x_taken != bus.x_pred_taken)) m_mis = m_mis + 32'd1;
            end
        end
        cnt_q.delete();
        cnt_q.push_back({m_br, m_mis});
        @(negedge clk);
    endtask

    task automatic test_reset();
        comb_t o, e;
        logic [63:0] c;
        logic [31:0] pc;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h100 + 32'(i * 4), 32'h900, 1'b1, 32'h80, 32'h90, 1'b1, 1'b0, 1'b0);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o !== comb_t'(0)) begin
                n_fail++; $display("FAIL reset_outputs: got %h expected %h", o, e);
            end
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = $urandom() & 32'hFFFF_FFFC;
            fetch_step(pc, 32'h500);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o.pred !== 1'b0 || o.rv !== 1'b0) begin
                n_fail++; $display("FAIL reset_pred pc=%h: got %h expected %h", pc, o, e);
            end
            tick();
            c = cnt_q.pop_front(); n_run++;
            if ({bus.br_count, bus.mispred_count} !== c || c !== 64'd0) begin
                n_fail++; $display("FAIL reset_counts: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
            end
        end
    endtask

    task automatic test_train();
        comb_t o, e;
        logic [63:0] c;
        for (int i = 0; i < 2; i++) begin
            exec_step(32'h100, 32'h140, 1'b1, 1'b0);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o.rpc !== 32'h140 || o.fl !== 1'b1) begin
                n_fail++; $display("FAIL train_mispredict %0d: got %h expected %h", i, o, e);
            end
            tick();
        end
        fetch_step(32'h100, 32'h1A0);
        o = obs(); e = comb_q.pop_front(); n_run++;
        if (o !== e || o.pred !== 1'b1 || o.rpc !== 32'h1A0 || o.fl !== 1'b0) begin
            n_fail++; $display("FAIL train_predict: got %h expected %h", o, e);
        end
        tick();
        c = cnt_q.pop_front(); n_run++;
        if ({bus.br_count, bus.mispred_count} !== c || c !== {32'd2, 32'd2}) begin
            n_fail++; $display("FAIL train_counts: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
        end
    endtask

    task automatic test_saturation();
        comb_t o, e;
        logic outcome [7];
        outcome = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            exec_step(32'h40, 32'h400, outcome[i], 1'b1);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++; $display("FAIL sat_update %0d: got %h expected %h", i, o, e);
            end
            tick();
            if (i >= 5) begin
                fetch_step(32'h40, 32'h444);
                o = obs(); e = comb_q.pop_front(); n_run++;
                if (o !== e || o.pred !== (i == 5)) begin
                    n_fail++; $display("FAIL sat_predict %0d: got %h expected %h", i, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_simultaneous();
        comb_t o, e;
        step(1'b1, 32'h100, 32'h200, 1'b1, 32'h80, 32'h88, 1'b0, 1'b1, 1'b0);
        o = obs(); e = comb_q.pop_front(); n_run++;
        if (o !== e || o.rpc !== 32'h84 || o.fl !== 1'b1 || o.pred !== 1'b1) begin
            n_fail++; $display("FAIL simul_priority: got %h expected %h", o, e);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o.pred !== 1'b1 || o.rpc !== 32'h104) begin
                n_fail++; $display("FAIL simul_read_old %0d: got %h expected %h", i, o, e);
            end
            tick();
        end
        fetch_step(32'h100, 32'h200);
        o = obs(); e = comb_q.pop_front(); n_run++;
        if (o !== e || o.pred !== 1'b0) begin
            n_fail++; $display("FAIL simul_after: got %h expected %h", o, e);
        end
        tick();
    endtask

    task automatic test_alias();
        comb_t o, e;
        for (int i = 0; i < 2; i++) begin
            fetch_step(32'h104, 32'h800);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o.pred !== (i == 1)) begin
                n_fail++; $display("FAIL alias_predict %0d: got %h expected %h", i, o, e);
            end
            tick();
            if (i == 0) begin
                exec_step(32'h004, 32'h040, 1'b1, 1'b1);
                tick();
                void'(comb_q.pop_front());
            end
        end
    endtask

    task automatic test_back_to_back();
        comb_t o, e;
        logic outcome [3];
        outcome = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exec_step(32'h300, 32'h380, outcome[i], 1'b0);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++; $display("FAIL b2b_update %0d: got %h expected %h", i, o, e);
            end
            tick();
        end
        fetch_step(32'h300, 32'h3C0);
        o = obs(); e = comb_q.pop_front(); n_run++;
        if (o !== e || o.pred !== 1'b1) begin
            n_fail++; $display("FAIL b2b_predict: got %h expected %h", o, e);
        end
        tick();
    endtask

    task automatic test_counters();
        logic [63:0] c;
        logic [31:0] exp_br;
        force dut.mispred_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_count_r;
        m_mis = 32'hFFFF_FFFF;
        exp_br = m_br + 32'd1;
        n_run++;
        if (bus.mispred_count !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL cnt_preload: got %h expected ffffffff", bus.mispred_count);
        end
        exec_step(32'h10, 32'h20, 1'b1, 1'b0);
        void'(comb_q.pop_front());
        tick();
        c = cnt_q.pop_front(); n_run++;
        if ({bus.br_count, bus.mispred_count} !== c || c !== {exp_br, 32'd0}) begin
            n_fail++; $display("FAIL cnt_wrap: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1);
        void'(comb_q.pop_front());
        tick();
        c = cnt_q.pop_front(); n_run++;
        if ({bus.br_count, bus.mispred_count} !== c || c !== 64'd0) begin
            n_fail++; $display("FAIL cnt_clear: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
        end
        exec_step(32'h10, 32'h20, 1'b1, 1'b1);
        void'(comb_q.pop_front());
        tick();
        c = cnt_q.pop_front(); n_run++;
        if ({bus.br_count, bus.mispred_count} !== c || c !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL cnt_after_clear: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
        end
    endtask

    task automatic test_reset_mid();
        comb_t o, e;
        logic [63:0] c;
        logic [31:0] pcs [4];
        pcs = '{32'h100, 32'h040, 32'h104, 32'h300};
        rst_n = 1'b0;
        exec_step(32'h100, 32'h140, 1'b1, 1'b0);
        void'(comb_q.pop_front());
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_step(pcs[i], 32'h600);
            o = obs(); e = comb_q.pop_front(); n_run++;
            if (o !== e || o.pred !== 1'b0) begin
                n_fail++; $display("FAIL midreset_pred pc=%h: got %h expected %h", pcs[i], o, e);
            end
            tick();
        end
        exec_step(32'h100, 32'h140, 1'b1, 1'b0);
        void'(comb_q.pop_front());
        tick();
        fetch_step(32'h100, 32'h600);
        o = obs(); e = comb_q.pop_front(); n_run++;
        if (o !== e || o.pred !== 1'b1) begin
            n_fail++; $display("FAIL midreset_weak: got %h expected %h", o, e);
        end
        tick();
        c = cnt_q.pop_front(); n_run++;
        if ({bus.br_count, bus.mispred_count} !== c || c !== {32'd1, 32'd1}) begin
            n_fail++; $display("FAIL midreset_counts: got %h expected %h", {bus.br_count, bus.mispred_count}, c);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; n_run = 0; n_fail = 0;
        m_br = 32'd0; m_mis = 32'd0;
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        bus.f_valid = 1'b0; bus.f_is_branch = 1'b0; bus.f_pc = 32'd0; bus.f_target = 32'd0;
        bus.x_valid = 1'b0; bus.x_pc = 32'd0; bus.x_target = 32'd0;
        bus.x_taken = 1'b0; bus.x_pred_taken = 1'b0; bus.cnt_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_train();
        test_saturation();
        test_simultaneous();
        test_alias();
        test_back_to_back();
        test_counters();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
